cic_comb_decimator: RTL and testbench

- Downstream neighbour of the bit-stream accumulator/integrator in the sigma-delta decimation filter.
- Consumes the free-running integrator word, decimates by R = 2^DEC_LOG2, and runs N_STAGES comb (differentiator) stages at the decimated rate.
- Presents the filtered PCM word on a valid/ready output port with a single holding register.

---
 rtl/cic_comb_decimator_pkg.sv | 21 ++
 rtl/cic_comb_decimator_comb_stage.sv | 37 +++
 rtl/cic_comb_decimator.sv | 175 +++++++++++++++++
 tb/tb_cic_comb_decimator.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comb_decimator_pkg.sv
// Shared constants, FSM state type and width-budget helper for the CIC comb
// decimator. Optional rounding output stage is enabled with ROUND_EN.
package cic_pkg;

  localparam int IN_W_DEF     = 16;
  localparam int N_STAGES_DEF = 3;
  localparam int DEC_LOG2_DEF = 4;
  localparam int OUT_W_DEF    = 16;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Bits needed so the modular CIC arithmetic recovers the true result:
  // sign + register growth of N stages at ratio 2^dec_log2 + input signal bits.
  function automatic int req_in_w(int n_stages, int dec_log2, int sig_bits);
    return 1 + n_stages * dec_log2 + sig_bits;
  endfunction

endpackage

// File: rtl/cic_comb_decimator_comb_stage.sv
// Single CIC differentiator: y = x - x_prev on each valid input, modulo 2^W.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = IN_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] x_i,
  output logic         out_valid_o,
  output logic [W-1:0] y_o
);

  logic [W-1:0] d_q;
  logic [W-1:0] y_q;
  logic         vld_q;

  // Difference and delay update only on valid input; wrap-around is intended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid_i;
      if (in_valid_i) begin
        y_q <= x_i - d_q;
        d_q <= x_i;
      end
    end
  end

  assign out_valid_o = vld_q;
  assign y_o         = y_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: decimate the integrator word by 2^DEC_LOG2, run
// N_STAGES comb stages, discard the priming transient, and hold the result in
// a single valid/ready output register. Define ROUND_EN for round-half-up
// with positive saturation (one extra cycle when OUT_W < IN_W).
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int IN_W     = IN_W_DEF,
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int DEC_LOG2 = DEC_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  acc_in,
  input  logic             acc_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int PCW = $clog2(N_STAGES + 1);
  localparam logic [PCW-1:0] PRIME_LAST = PCW'(N_STAGES - 1);

  if (IN_W < req_in_w(N_STAGES, DEC_LOG2, 1)) begin : g_w_chk
    $error("cic_comb_decimator: IN_W too narrow for comb growth");
  end
  if (OUT_W > IN_W) begin : g_o_chk
    $error("cic_comb_decimator: OUT_W must not exceed IN_W");
  end

  logic [DEC_LOG2-1:0] dec_cnt_q, dec_cnt_d;
  logic                strobe;

  // Decimation counter advances only on valid input samples.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (acc_valid) dec_cnt_d = dec_cnt_q + DEC_LOG2'(1);
  end

  // Decimation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dec_cnt_q <= '0;
    else        dec_cnt_q <= dec_cnt_d;
  end

  assign strobe = acc_valid && (&dec_cnt_q);

  logic [N_STAGES:0][IN_W-1:0] x_chain;
  logic [N_STAGES:0]           vld_chain;

  assign x_chain[0]   = acc_in;
  assign vld_chain[0] = strobe;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    cic_comb_stage #(.W(IN_W)) u_stage (
      .clk         (clk),
      .rst_n       (reset),
      .in_valid_i  (vld_chain[k]),
      .x_i         (x_chain[k]),
      .out_valid_o (vld_chain[k+1]),
      .y_o         (x_chain[k+1])
    );
  end

  logic [IN_W-1:0] y_fin;
  logic            y_vld;
  assign y_fin = x_chain[N_STAGES];
  assign y_vld = vld_chain[N_STAGES];

  state_e          state_q, state_d;
  logic [PCW-1:0]  prime_cnt_q, prime_cnt_d;
  logic            res_take;

  // Drop the first N_STAGES chain results (delay lines still filling).
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    res_take    = 1'b0;
    case (state_q)
      PRIME: if (y_vld) begin
        prime_cnt_d = prime_cnt_q + PCW'(1);
        if (prime_cnt_q == PRIME_LAST) state_d = RUN;
      end
      RUN:   res_take = y_vld;
      default: state_d = PRIME;
    endcase
  end

  // Priming FSM registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  logic [OUT_W-1:0] new_data;
  logic             new_vld;

`ifdef ROUND_EN
  if (OUT_W < IN_W) begin : g_rnd
    localparam logic [OUT_W-1:0] MAX_POS = OUT_W'((1 << (OUT_W - 1)) - 1);
    logic [OUT_W-1:0] trunc, rnd_d, rnd_q;
    logic             rbit, rnd_vld_q;
    assign trunc = y_fin[IN_W-1 -: OUT_W];
    assign rbit  = y_fin[IN_W-OUT_W-1];
    // Saturate instead of wrapping past the largest positive code.
    assign rnd_d = (trunc == MAX_POS) ? trunc : trunc + OUT_W'(rbit);
    // Extra pipeline cycle for the rounding adder.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rnd_q     <= '0;
        rnd_vld_q <= 1'b0;
      end else begin
        rnd_vld_q <= res_take;
        if (res_take) rnd_q <= rnd_d;
      end
    end
    assign new_data = rnd_q;
    assign new_vld  = rnd_vld_q;
  end else begin : g_nornd
    assign new_data = y_fin[IN_W-1 -: OUT_W];
    assign new_vld  = res_take;
  end
`else
  assign new_data = y_fin[IN_W-1 -: OUT_W];
  assign new_vld  = res_take;
`endif

  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             drain;

  // Holding register: load when empty or draining, else drop and flag.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    drain       = out_valid_q && out_ready;
    if (new_vld) begin
      if (!out_valid_q || drain) begin
        out_data_d  = new_data;
        out_valid_d = 1'b1;
      end else begin
        overflow_d  = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Output port registers; overflow is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator: two instances (N=1,R=4 and N=3,R=16) share
// stimulus; a reference model computes each output as the N-th finite
// difference of the decimated samples (binomial sum) and tracks the port.
module tb_cic_comb_decimator;

  localparam int NA = 1, DA = 2, NB = 3, DB = 4;
  localparam int MN [2] = '{NA, NB};
  localparam int MR [2] = '{1 << DA, 1 << DB};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        acc_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] acc_in = '0;
  logic [15:0] od_a, od_b;
  logic        ov_a, ov_b, of_a, of_b;
  logic [15:0] od [2];
  logic        ov [2];
  logic        of [2];

  assign od[0] = od_a; assign od[1] = od_b;
  assign ov[0] = ov_a; assign ov[1] = ov_b;
  assign of[0] = of_a; assign of[1] = of_b;

  always #5 clk = ~clk;

  cic_comb_decimator #(.IN_W(16), .N_STAGES(NA), .DEC_LOG2(DA), .OUT_W(16)) dut_a (
    .clk(clk), .reset(reset), .acc_in(acc_in), .acc_valid(acc_valid),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready), .overflow(of_a));

  cic_comb_decimator #(.IN_W(16), .N_STAGES(NB), .DEC_LOG2(DB), .OUT_W(16)) dut_b (
    .clk(clk), .reset(reset), .acc_in(acc_in), .acc_valid(acc_valid),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready), .overflow(of_b));

  int n_chk = 0, n_pass = 0;

  // reference model state
  int          cyc = 0;
  int          dcnt [2], nres [2], pdue [2];
  logic [15:0] hist [2][4];
  logic        pv [2], hv [2], ovf [2];
  logic [15:0] pval [2], hd [2];

  function automatic int binom(int n, int j);
    int c = 1;
    for (int k = 0; k < j; k++) c = c * (n - k) / (k + 1);
    return c;
  endfunction

  // N-th order difference of the newest decimated samples, mod 2^16
  function automatic logic [15:0] comb_ref(int i);
    logic [15:0] y = '0, t;
    for (int j = 0; j <= MN[i]; j++) begin
      t = 16'(binom(MN[i], j) * int'(hist[i][j]));
      if (j % 2 == 1) y = y - t; else y = y + t;
    end
    return y;
  endfunction

  // advance model across the coming clock edge using current inputs
  task automatic model_update();
    logic nw, dr;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        dcnt[i] = 0; nres[i] = 0; pv[i] = 0; hv[i] = 0; ovf[i] = 0; hd[i] = '0;
        for (int j = 0; j < 4; j++) hist[i][j] = '0;
      end else begin
        nw = pv[i] && (pdue[i] == cyc);
        if (nw) pv[i] = 0;
        dr = hv[i] && out_ready;
        if (nw) begin
          if (!hv[i] || dr) begin hv[i] = 1; hd[i] = pval[i]; end
          else ovf[i] = 1;
        end else if (dr) hv[i] = 0;
        if (acc_valid) begin
          if (dcnt[i] == MR[i] - 1) begin
            for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = acc_in;
            nres[i]++;
            if (nres[i] > MN[i]) begin
              pv[i] = 1; pdue[i] = cyc + MN[i]; pval[i] = comb_ref(i);
            end
          end
          dcnt[i] = (dcnt[i] + 1) % MR[i];
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 0; acc_valid = 0; out_ready = 0;
    step(); step();
    reset = 1;
  endtask

  task automatic test_reset();
    #1 reset = 0;
    #2;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ov[i] !== 0 || od[i] !== 16'h0 || of[i] !== 0)
        $display("FAIL reset[%0d]: got v=%b d=%h o=%b, expected all 0", i, ov[i], od[i], of[i]);
      else n_pass++;
    end
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ov[i] !== 0 || od[i] !== 16'h0 || of[i] !== 0)
        $display("FAIL reset_rel[%0d]: got v=%b d=%h o=%b, expected all 0", i, ov[i], od[i], of[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ramp(input logic [15:0] start, input string tag);
    int nout = 0;
    apply_reset();
    acc_in = start; acc_valid = 1; out_ready = 1;
    for (int c = 0; c < 48; c++) begin
      step();
      acc_in = acc_in + 16'd3;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ov[i] !== hv[i] || od[i] !== hd[i] || of[i] !== ovf[i])
          $display("FAIL %s[%0d] c=%0d: got v=%b d=%h o=%b, expected v=%b d=%h o=%b",
                   tag, i, c, ov[i], od[i], of[i], hv[i], hd[i], ovf[i]);
        else n_pass++;
      end
      if (ov[0]) begin
        nout++;
        n_chk++;
        if (od[0] !== 16'd12 || of[0] !== 0)
          $display("FAIL %s_val c=%0d: got d=%h o=%b, expected d=000c o=0", tag, c, od[0], of[0]);
        else n_pass++;
      end
    end
    n_chk++;
    if (nout != 10) $display("FAIL %s_count: got %0d outputs, expected 10", tag, nout);
    else n_pass++;
  endtask

  task automatic test_const();
    int first = -1;
    apply_reset();
    acc_in = 16'h1234; acc_valid = 1; out_ready = 1;
    for (int c = 0; c < 130; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ov[i] !== hv[i] || od[i] !== hd[i] || of[i] !== ovf[i])
          $display("FAIL const[%0d] c=%0d: got v=%b d=%h o=%b, expected v=%b d=%h o=%b",
                   i, c, ov[i], od[i], of[i], hv[i], hd[i], ovf[i]);
        else n_pass++;
      end
      if (ov[1]) begin
        if (first < 0) first = c;
        n_chk++;
        if (od[1] !== 16'h0) $display("FAIL const_val c=%0d: got %h, expected 0000", c, od[1]);
        else n_pass++;
      end
    end
    n_chk++;
    if (first != 66) $display("FAIL const_latency: first out_valid at %0d, expected 66", first);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    acc_in = '0; acc_valid = 1; out_ready = 0;
    for (int c = 0; c < 25; c++) begin
      if (c == 14) out_ready = 1;
      if (c == 15) out_ready = 0;
      step();
      acc_in = acc_in + 16'd3;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ov[i] !== hv[i] || od[i] !== hd[i] || of[i] !== ovf[i])
          $display("FAIL ovf[%0d] c=%0d: got v=%b d=%h o=%b, expected v=%b d=%h o=%b",
                   i, c, ov[i], od[i], of[i], hv[i], hd[i], ovf[i]);
        else n_pass++;
      end
      if (c == 13) begin
        n_chk++;
        if (ov[0] !== 1 || od[0] !== 16'd12 || of[0] !== 1)
          $display("FAIL ovf_hold: got v=%b d=%h o=%b, expected v=1 d=000c o=1", ov[0], od[0], of[0]);
        else n_pass++;
      end
      if (c == 14) begin
        n_chk++;
        if (ov[0] !== 0 || of[0] !== 1)
          $display("FAIL ovf_drain: got v=%b o=%b, expected v=0 o=1", ov[0], of[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int hits = 0;
    apply_reset();
    acc_in = '0; acc_valid = 1; out_ready = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (hv[0] && pv[0] && pdue[0] == cyc);
      step();
      acc_in = acc_in + 16'd3;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ov[i] !== hv[i] || od[i] !== hd[i] || of[i] !== ovf[i])
          $display("FAIL b2b[%0d] c=%0d: got v=%b d=%h o=%b, expected v=%b d=%h o=%b",
                   i, c, ov[i], od[i], of[i], hv[i], hd[i], ovf[i]);
        else n_pass++;
      end
      if (out_ready) begin
        hits++;
        n_chk++;
        if (ov[0] !== 1 || od[0] !== 16'd12 || of[0] !== 0)
          $display("FAIL b2b_load c=%0d: got v=%b d=%h o=%b, expected v=1 d=000c o=0", c, ov[0], od[0], of[0]);
        else n_pass++;
      end
    end
    n_chk++;
    if (hits == 0) $display("FAIL b2b_hit: got 0 coincident loads, expected >0");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    apply_reset();
    acc_in = '0; acc_valid = 1; out_ready = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      acc_in = acc_in + 16'd3;
    end
    #2 reset = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ov[i] !== 0 || od[i] !== 16'h0 || of[i] !== 0)
        $display("FAIL midrst[%0d]: got v=%b d=%h o=%b, expected all 0", i, ov[i], od[i], of[i]);
      else n_pass++;
    end
    step();
    reset = 1; out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      acc_in = acc_in + 16'd3;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ov[i] !== hv[i] || od[i] !== hd[i] || of[i] !== ovf[i])
          $display("FAIL midrst_run[%0d] c=%0d: got v=%b d=%h o=%b, expected v=%b d=%h o=%b",
                   i, c, ov[i], od[i], of[i], hv[i], hd[i], ovf[i]);
        else n_pass++;
      end
      if (ov[0] && first < 0) first = c;
    end
    n_chk++;
    if (first != 8) $display("FAIL midrst_prime: first out_valid at %0d, expected 8", first);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      acc_valid = ($urandom_range(0, 3) != 0);
      acc_in    = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ov[i] !== hv[i] || od[i] !== hd[i] || of[i] !== ovf[i])
          $display("FAIL rand[%0d] c=%0d: got v=%b d=%h o=%b, expected v=%b d=%h o=%b",
                   i, c, ov[i], od[i], of[i], hv[i], hd[i], ovf[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp(16'h0000, "ramp");
    test_ramp(16'hFFF0, "wrap");
    test_const();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
